// File: rtl/prod_acc_pkg.sv
// ----------------------------------------------------------------------------
// prod_acc_pkg
//   Shared definitions for the product accumulator slice: default widths,
//   group length, the group FSM state type and a counter-width helper.
// ----------------------------------------------------------------------------
package prod_acc_pkg;

    // Defaults match the 4x4 multiplier feeding this stage (8-bit products).
    localparam int PROD_W_DEF = 8;
    localparam int LEN_DEF    = 4;
    localparam int ACC_W_DEF  = 12;

    // Group FSM: IDLE means no beat of the current group has been taken yet.
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } grp_state_t;

    // Width of the beat counter; it only has to count 0..len-1.
    function automatic int cnt_w(input int len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction

endpackage

// File: rtl/result_slot_reg.sv
// ----------------------------------------------------------------------------
// result_slot_reg
//   Single-entry valid/ready holding register for the group result.
//   A load always wins over a drain in the same cycle, so a new result can
//   replace a departing one with valid staying high (no bubble).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (empties the slot, clears data)
//   load       write load_data into the slot this cycle
//   load_data  {overflow, sum} to store
//   drain      consumer ready; empties a full slot when not reloaded
//   data       stored {overflow, sum}, stable while valid=1
//   valid      slot full
// ----------------------------------------------------------------------------
module result_slot_reg #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         drain,
    output logic [W-1:0] data,
    output logic         valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// ----------------------------------------------------------------------------
// product_accumulator
//   Sums each group of LEN accepted products from the multiplier into one
//   result and offers it through a valid/ready output slot. Adds are done one
//   bit wider than the accumulator; the carry bit feeds a sticky overflow flag
//   while the stored sum wraps modulo 2^ACC_W.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset (clears group and output slot)
//   prod_in     unsigned product from the multiplier
//   prod_valid  prod_in valid this cycle
//   prod_ready  stage can take a beat (slot empty or being drained)
//   clear       abort the partial group; output slot untouched
//   sum_out     group sum, stable while sum_valid=1
//   sum_valid   output slot full
//   sum_ready   consumer takes sum_out this cycle
//   overflow    group sum exceeded 2^ACC_W-1, qualified by sum_valid
//   grp_cnt     beats accepted in the current group
//
// Legal parameter range: 2 <= LEN <= 16, ACC_W >= PROD_W+1.
// ----------------------------------------------------------------------------
module product_accumulator
    import prod_acc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int LEN    = LEN_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PROD_W-1:0]         prod_in,
    input  logic                      prod_valid,
    output logic                      prod_ready,
    input  logic                      clear,
    output logic [ACC_W-1:0]          sum_out,
    output logic                      sum_valid,
    input  logic                      sum_ready,
    output logic                      overflow,
    output logic [cnt_w(LEN)-1:0]     grp_cnt
);

    localparam int CNT_W = cnt_w(LEN);

    // Zero-extended add; bit ACC_W of the result is the carry out.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [PROD_W-1:0] p);
        return {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, p};
    endfunction

    grp_state_t         state_p0;
    logic [ACC_W-1:0]   acc_p0;
    logic [CNT_W-1:0]   cnt_p0;
    logic               ovf_p0;

    logic [ACC_W:0]     sum_wide;
    logic               beat_acc;
    logic               last_beat;
    logic [ACC_W:0]     slot_data;

    // Stalled only while a result sits unread in the slot.
    assign prod_ready = !sum_valid || sum_ready;

    // clear drops any beat presented in the same cycle.
    assign beat_acc  = prod_valid && prod_ready && !clear;
    assign sum_wide  = acc_add(acc_p0, prod_in);
    assign last_beat = beat_acc && (state_p0 == ACCUM) && (cnt_p0 == CNT_W'(LEN - 1));

    // Stage p0: group accumulator and beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= IDLE;
            acc_p0   <= '0;
            cnt_p0   <= '0;
            ovf_p0   <= 1'b0;
        end else if (clear) begin
            state_p0 <= IDLE;
            acc_p0   <= '0;
            cnt_p0   <= '0;
            ovf_p0   <= 1'b0;
        end else if (beat_acc) begin
            case (state_p0)
                IDLE: begin
                    acc_p0   <= ACC_W'(prod_in);
                    cnt_p0   <= CNT_W'(1);
                    ovf_p0   <= 1'b0;
                    state_p0 <= ACCUM;
                end
                ACCUM: begin
                    if (cnt_p0 == CNT_W'(LEN - 1)) begin
                        // Final beat: the result moves to the slot, group restarts.
                        acc_p0   <= '0;
                        cnt_p0   <= '0;
                        ovf_p0   <= 1'b0;
                        state_p0 <= IDLE;
                    end else begin
                        acc_p0 <= sum_wide[ACC_W-1:0];
                        cnt_p0 <= cnt_p0 + CNT_W'(1);
                        ovf_p0 <= ovf_p0 | sum_wide[ACC_W];
                    end
                end
                default: begin
                    state_p0 <= IDLE;
                    acc_p0   <= '0;
                    cnt_p0   <= '0;
                    ovf_p0   <= 1'b0;
                end
            endcase
        end
    end

    // Stage p1: output slot holding {overflow, sum}
    result_slot_reg #(
        .W (ACC_W + 1)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (last_beat),
        .load_data ({ovf_p0 | sum_wide[ACC_W], sum_wide[ACC_W-1:0]}),
        .drain     (sum_ready),
        .data      (slot_data),
        .valid     (sum_valid)
    );

    assign sum_out  = slot_data[ACC_W-1:0];
    assign overflow = slot_data[ACC_W];
    assign grp_cnt  = cnt_p0;

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

    typedef struct packed {
        logic [11:0] sum;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [3:0][7:0] p;
        int unsigned     sum;
        bit              ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    // DUT A: default widths (ACC_W=12)
    logic [7:0]  a_in;
    logic        a_valid, a_ready, a_clear, a_sv, a_sr, a_ovf;
    logic [11:0] a_sum;
    logic [1:0]  a_cnt;

    // DUT B: narrow accumulator (ACC_W=9) for wrap/overflow
    logic [7:0]  b_in;
    logic        b_valid, b_ready, b_clear, b_sv, b_sr, b_ovf;
    logic [8:0]  b_sum;
    logic [1:0]  b_cnt;

    int checks   = 0;
    int failures = 0;

    exp_t qa[$];
    exp_t qb[$];

    vec_t tab_a[5];
    vec_t tab_b[3];

    always #5 clk = ~clk;

    product_accumulator dut_a (
        .clk(clk), .rst(rst), .prod_in(a_in), .prod_valid(a_valid),
        .prod_ready(a_ready), .clear(a_clear), .sum_out(a_sum),
        .sum_valid(a_sv), .sum_ready(a_sr), .overflow(a_ovf), .grp_cnt(a_cnt)
    );

    product_accumulator #(.PROD_W(8), .LEN(4), .ACC_W(9)) dut_b (
        .clk(clk), .rst(rst), .prod_in(b_in), .prod_valid(b_valid),
        .prod_ready(b_ready), .clear(b_clear), .sum_out(b_sum),
        .sum_valid(b_sv), .sum_ready(b_sr), .overflow(b_ovf), .grp_cnt(b_cnt)
    );

    function automatic vec_t mk(input int a, input int b, input int c, input int d,
                                input int s, input bit o);
        vec_t v;
        v.p[0] = 8'(a); v.p[1] = 8'(b); v.p[2] = 8'(c); v.p[3] = 8'(d);
        v.sum = s; v.ovf = o;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Scoreboard: a transfer is seen at the negedge before the edge that takes it.
    task automatic monitor();
        exp_t e;
        if (!rst && a_sv && a_sr) begin
            checks++;
            if (qa.size() == 0) begin
                failures++;
                $display("FAIL a_unexpected: got sum=%0d ovf=%0d expected none", a_sum, a_ovf);
            end else begin
                e = qa.pop_front();
                if (a_sum !== e.sum || a_ovf !== e.ovf) begin
                    failures++;
                    $display("FAIL a_result: got sum=%0d ovf=%0d expected sum=%0d ovf=%0d",
                             a_sum, a_ovf, e.sum, e.ovf);
                end
            end
        end
        if (!rst && b_sv && b_sr) begin
            checks++;
            if (qb.size() == 0) begin
                failures++;
                $display("FAIL b_unexpected: got sum=%0d ovf=%0d expected none", b_sum, b_ovf);
            end else begin
                e = qb.pop_front();
                if ({3'b0, b_sum} !== e.sum || b_ovf !== e.ovf) begin
                    failures++;
                    $display("FAIL b_result: got sum=%0d ovf=%0d expected sum=%0d ovf=%0d",
                             b_sum, b_ovf, e.sum, e.ovf);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and returns after the edge that accepts it.
    task automatic drive_beat(input bit sel, input logic [7:0] p, output int waits);
        int n;
        n = 0;
        if (!sel) begin a_valid = 1'b1; a_in = p; end
        else      begin b_valid = 1'b1; b_in = p; end
        while ((sel ? b_ready : a_ready) !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        waits = n;
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout: got prod_ready=0 for %0d cycles expected 1", n);
        end else begin
            tick();
        end
    endtask

    task automatic send_group(input bit sel, input vec_t v, input bit expect_no_stall);
        int w;
        int total;
        exp_t e;
        e.sum = 12'(v.sum);
        e.ovf = v.ovf;
        if (!sel) qa.push_back(e); else qb.push_back(e);
        total = 0;
        for (int i = 0; i < 4; i++) begin
            drive_beat(sel, v.p[i], w);
            total += w;
        end
        if (expect_no_stall) check("no_stall", total, 0);
        check("latency_sum_valid", sel ? b_sv : a_sv, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1;
        a_in = '0; a_valid = 1'b0; a_clear = 1'b0; a_sr = 1'b0;
        b_in = '0; b_valid = 1'b0; b_clear = 1'b0; b_sr = 1'b0;

        tab_a[0] = mk(1, 4, 9, 16, 30, 0);
        tab_a[1] = mk(25, 36, 49, 64, 174, 0);
        tab_a[2] = mk(1, 1, 1, 1, 4, 0);
        tab_a[3] = mk(255, 255, 255, 255, 1020, 0);
        tab_a[4] = mk(0, 0, 0, 0, 0, 0);
        tab_b[0] = mk(225, 225, 225, 225, 388, 1);
        tab_b[1] = mk(1, 2, 3, 4, 10, 0);
        tab_b[2] = mk(100, 100, 100, 250, 38, 1);

        tick(); tick();
        check("reset_sum_valid", a_sv, 0);
        check("reset_sum_out", a_sum, 0);
        check("reset_grp_cnt", a_cnt, 0);
        check("reset_overflow", a_ovf, 0);
        check("reset_prod_ready", a_ready, 1);
        rst = 1'b0;
        a_sr = 1'b1;
        b_sr = 1'b1;
        tick();

        // Back-to-back groups, continuous valid, consumer always ready
        for (int i = 0; i < 5; i++) send_group(0, tab_a[i], 1);
        a_valid = 1'b0;
        tick();

        // Narrow accumulator: wrap and sticky/final-carry overflow
        for (int i = 0; i < 3; i++) send_group(1, tab_b[i], 1);
        b_valid = 1'b0;
        tick();

        // Result held under back-pressure; beats refused meanwhile
        a_sr = 1'b0;
        send_group(0, mk(25, 36, 49, 64, 174, 0), 1);
        check("hold_sum_out", a_sum, 174);
        for (int i = 0; i < 3; i++) begin
            check("hold_prod_ready", a_ready, 0);
            a_valid = 1'b1;
            a_in = 8'd1;
            tick();
            check("hold_grp_cnt", a_cnt, 0);
            check("hold_sum_stable", a_sum, 174);
        end
        a_valid = 1'b0;
        a_sr = 1'b1;
        tick();
        check("drained_sum_valid", a_sv, 0);
        send_group(0, mk(1, 1, 1, 1, 4, 0), 1);
        a_valid = 1'b0;
        tick();

        // clear discards the partial group and the beat presented with it
        drive_beat(0, 8'd9, w);
        drive_beat(0, 8'd9, w);
        check("pre_clear_grp_cnt", a_cnt, 2);
        a_clear = 1'b1;
        a_in = 8'd50;
        tick();
        a_clear = 1'b0;
        a_valid = 1'b0;
        check("post_clear_grp_cnt", a_cnt, 0);
        send_group(0, mk(1, 2, 3, 4, 10, 0), 1);
        a_valid = 1'b0;
        tick();

        // Reset mid-group
        drive_beat(0, 8'd9, w);
        drive_beat(0, 8'd9, w);
        check("pre_rst_grp_cnt", a_cnt, 2);
        rst = 1'b1;
        a_in = 8'd77;
        tick();
        rst = 1'b0;
        a_valid = 1'b0;
        check("rst_mid_grp_cnt", a_cnt, 0);

        // Reset with a pending result discards it
        a_sr = 1'b0;
        send_group(0, mk(25, 36, 49, 64, 174, 0), 1);
        a_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(qa.pop_back());
        check("rst_pending_sum_valid", a_sv, 0);
        check("rst_pending_sum_out", a_sum, 0);
        check("rst_pending_overflow", a_ovf, 0);
        check("rst_pending_grp_cnt", a_cnt, 0);
        a_sr = 1'b1;
        send_group(0, mk(1, 4, 9, 16, 30, 0), 1);
        a_valid = 1'b0;
        repeat (3) tick();

        check("queue_a_drained", qa.size(), 0);
        check("queue_b_drained", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
